// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and sizing constants for the shift sequencer.
package shift_pkg;
    localparam int WIDTH = 32;
    localparam int COARSE_STEP = 4;
    localparam int AMT_W = 5;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/shift_step32.sv
// shift_step32: one combinational shift step of 4 bits (coarse) or 1 bit (fine).
// Rotation support is compiled in with SHIFT_SEQ_ROTATE_EN.
module shift_step32
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic             arith,
    input  logic             coarse,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] result
);
    logic rot;
    logic fill;
`ifdef SHIFT_SEQ_ROTATE_EN
    assign rot = rotate;
`else
    assign rot = 1'b0;
`endif
    // Sign fill only applies to non-rotating right shifts; left callers never see it.
    assign fill = arith & ~rot & data[WIDTH-1];
    always_comb
        result = coarse
            ? (dir ? {data[WIDTH-COARSE_STEP-1:0], rot ? data[WIDTH-1 -: COARSE_STEP] : {COARSE_STEP{1'b0}}}
                   : {rot ? data[COARSE_STEP-1:0] : {COARSE_STEP{fill}}, data[WIDTH-1:COARSE_STEP]})
            : (dir ? {data[WIDTH-2:0], rot & data[WIDTH-1]}
                   : {rot ? data[0] : fill, data[WIDTH-1:1]});
endmodule

// File: rtl/shift_sequencer32.sv
// shift_sequencer32: multi-cycle variable-amount 32-bit shifter, start/done handshake.
// Define SHIFT_SEQ_ROTATE_EN to add the rotate input.
module shift_sequencer32
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] amount,
    input  logic             shiftdir,
    input  logic             shifta,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);
    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] stepped;
    logic [AMT_W-1:0] rem;
    logic             dir;
    logic             ar;
    logic             coarse;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             rot;
`endif

    assign coarse = rem >= AMT_W'(COARSE_STEP);

    shift_step32 u_step (
        .data   (work),
        .dir    (dir),
        .arith  (ar),
        .coarse (coarse),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate (rot),
`endif
        .result (stepped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            dir   <= 1'b0;
            ar    <= 1'b0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    work  <= in;
                    rem   <= amount;
                    dir   <= shiftdir;
                    ar    <= shifta;
                    busy  <= 1'b1;
                    state <= SHIFT;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot   <= rotate;
`endif
                end
                SHIFT: if (rem == '0) begin
                    out   <= work;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    work <= stepped;
                    rem  <= coarse ? rem - AMT_W'(COARSE_STEP) : rem - AMT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer32.sv
// tb_shift_sequencer32: directed checks of latency, busy window, results and reset abort.
module tb_shift_sequencer32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in = '0;
    logic [4:0]  amount = '0;
    logic        shiftdir = 1'b0;
    logic        shifta = 1'b0;
    logic        rotate = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] out;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    shift_sequencer32 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in       (in),
        .amount   (amount),
        .shiftdir (shiftdir),
        .shifta   (shifta),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate   (rotate),
`endif
        .busy     (busy),
        .done     (done),
        .out      (out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (cycle T).
    // chain: return right in the done cycle so the caller can launch there.
    task automatic op(input string tag, input logic [31:0] d, input logic [4:0] a,
                      input logic sd, input logic sa, input logic ro, input logic [31:0] exp,
                      input bit noise, input bit chain);
        int n, donek, dones, busyc;
        logic [31:0] res;
        n = int'(a) / 4 + int'(a) % 4;
        donek = 0; dones = 0; busyc = 0; res = 'x;
        in = d; amount = a; shiftdir = sd; shifta = sa; rotate = ro; start = 1'b1;
        for (int k = 1; k <= n + 8; k++) begin
            @(negedge clk);
            if (noise && (k == 3 || k == 7)) begin
                start = 1'b1; in = ~d; amount = ~a; shiftdir = ~sd; shifta = ~sa;
            end else
                start = 1'b0;
            if (busy) busyc++;
            if (done) begin
                if (dones == 0) begin donek = k; res = out; end
                dones++;
                if (chain) break;
            end
        end
        check({tag, "_done_cycle"}, 32'(donek), 32'(n + 2));
        check({tag, "_out"}, res, exp);
        check({tag, "_busy_cycles"}, 32'(busyc), 32'(n + 1));
        if (!chain) check({tag, "_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int dones;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", out, 32'h0);
        op("left4", 32'h000000F1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h00000F10, 0, 0);
        op("r7_arith", 32'h80000000, 5'd7, 1'b0, 1'b1, 1'b0, 32'hFF000000, 0, 0);
        op("r7_logic", 32'h80000000, 5'd7, 1'b0, 1'b0, 1'b0, 32'h01000000, 0, 0);
        op("amt0", 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 0, 0);
        op("l31_noise", 32'h00000001, 5'd31, 1'b1, 1'b0, 1'b0, 32'h80000000, 1, 0);
        op("left_arith_ignored", 32'hC0000003, 5'd9, 1'b1, 1'b1, 1'b0, 32'h00000600, 0, 0);
        op("chain_a", 32'h0000000F, 5'd6, 1'b1, 1'b0, 1'b0, 32'h000003C0, 0, 1);
        op("chain_b", 32'hF0000000, 5'd4, 1'b0, 1'b1, 1'b0, 32'hFF000000, 0, 0);
        // Abort a long shift with reset mid-flight.
        in = 32'h12345678; amount = 5'd31; shiftdir = 1'b1; shifta = 1'b0; start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", out, 32'h0);
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        op("after_abort", 32'h00000010, 5'd4, 1'b0, 1'b0, 1'b0, 32'h00000001, 0, 0);
`ifdef SHIFT_SEQ_ROTATE_EN
        op("rotr8", 32'h12345678, 5'd8, 1'b0, 1'b1, 1'b1, 32'h78123456, 0, 0);
        op("rotl5", 32'h80000001, 5'd5, 1'b1, 1'b0, 1'b1, 32'h00000030, 0, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
